// File: rtl/w_tile_pkg.sv
// Shared types and helpers for the w_tile ping-pong weight buffer.
package w_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_flag_e;

  // Number of column tiles needed to cover a K*K filter row.
  function automatic int tiles_for_kernel(input int k, input int column_width);
    return (k * k + column_width - 1) / column_width;
  endfunction

endpackage

// File: rtl/w_tile_bank.sv
// One ping-pong bank: ROW_WIDTH filter rows of storage plus its EMPTY/FULL flag.
module w_tile_bank
  import w_tile_pkg::*;
#(
  parameter int ROW_WIDTH = 10,
  parameter int ROW_BITS  = 864,
  parameter int ROW_AW    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_i,
  input  logic                          wr_en_i,
  input  logic [ROW_AW-1:0]             wr_row_i,
  input  logic [ROW_BITS-1:0]           wr_data_i,
  input  logic                          set_full_i,
  input  logic                          set_empty_i,
  output logic [ROW_WIDTH*ROW_BITS-1:0] rows_o,
  output bank_flag_e                    flag_o
);

  logic [ROW_BITS-1:0] mem_q [ROW_WIDTH];
  bank_flag_e          flag_q;

  // Row storage and fill flag; soft clear empties the bank like reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROW_WIDTH; r++) mem_q[r] <= '0;
      flag_q <= BANK_EMPTY;
    end else if (clr_i) begin
      for (int r = 0; r < ROW_WIDTH; r++) mem_q[r] <= '0;
      flag_q <= BANK_EMPTY;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_row_i] <= wr_data_i;
      end
      if (set_full_i) begin
        flag_q <= BANK_FULL;
      end else if (set_empty_i) begin
        flag_q <= BANK_EMPTY;
      end
    end
  end

  for (genvar r = 0; r < ROW_WIDTH; r++) begin : g_row
    assign rows_o[r*ROW_BITS +: ROW_BITS] = mem_q[r];
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/w_tile_pingpong.sv
// Ping-pong filter-row buffer streaming column tiles to conv_control.
// Build option W_ZERO_PAD_EN zeroes the unused tail elements of the last tile.
module w_tile_pingpong
  import w_tile_pkg::*;
#(
  parameter int ROW_WIDTH    = 10,
  parameter int COLUMN_WIDTH = 9,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_TILES    = 6,
  parameter int KERNEL_W     = 3,
  localparam int TIDX_W      = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sudo_reset,
  input  logic                                         conv_en,
  input  logic [KERNEL_W-1:0]                          kernel,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [MAX_TILES*COLUMN_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ROW_WIDTH*COLUMN_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic [TIDX_W-1:0]                            out_tile_idx,
  output logic                                         we_done,
  input  logic                                         we_valid_del,
  output logic                                         cfg_err
);

  localparam int TROW_BITS = COLUMN_WIDTH * DATA_WIDTH;
  localparam int ROW_BITS  = MAX_TILES * TROW_BITS;
  localparam int OUT_BITS  = ROW_WIDTH * TROW_BITS;
  localparam int ROW_AW    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam int NT_W      = $clog2(MAX_TILES + 1);

  state_e                   state_q, state_d;
  logic [NT_W-1:0]          nt_q, nt_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [ROW_AW-1:0]        wr_row_q, wr_row_d;
  logic [TIDX_W-1:0]        tile_q, tile_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]      out_data_q, out_data_d;
  logic                     we_done_q, we_done_d;

  logic                         clr_s;
  int                           nt_calc_s;
  logic                         nt_ok_s;
  logic                         run_s;
  logic                         in_ready_s;
  logic                         wr_fire_s;
  logic                         wr_last_s;
  logic                         rel_s;
  logic                         acc_s;
  logic                         last_tile_s;
  logic                         last_next_s;
  logic [ROW_WIDTH*ROW_BITS-1:0] rows_s [2];
  bank_flag_e                   flag_s [2];
  logic [ROW_WIDTH*ROW_BITS-1:0] rd_rows_s;
  logic [OUT_BITS-1:0]          tile_data_s;

  // Dropping conv_en returns to IDLE with the same clearing effect as reset.
  assign clr_s     = sudo_reset | ~conv_en;
  assign nt_calc_s = tiles_for_kernel(int'(kernel), COLUMN_WIDTH);
  assign nt_ok_s   = (nt_calc_s >= 1) && (nt_calc_s <= MAX_TILES);
  assign run_s     = (state_q == ST_RUN);

  assign in_ready_s  = run_s && (flag_s[wr_bank_q] == BANK_EMPTY);
  assign wr_fire_s   = in_valid && in_ready_s;
  assign wr_last_s   = (wr_row_q == ROW_AW'(ROW_WIDTH - 1));
  // The bank being read is FULL whenever anything is streamable, so that alone qualifies a release.
  assign rel_s       = we_valid_del && run_s && (flag_s[rd_bank_q] == BANK_FULL);
  assign acc_s       = out_valid_q && out_ready && !rel_s;
  assign last_tile_s = (NT_W'(tile_q) == nt_q - NT_W'(1));
  assign last_next_s = (NT_W'(tile_d) == nt_q - NT_W'(1));
  assign rd_rows_s   = rd_bank_q ? rows_s[1] : rows_s[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    w_tile_bank #(
      .ROW_WIDTH (ROW_WIDTH),
      .ROW_BITS  (ROW_BITS),
      .ROW_AW    (ROW_AW)
    ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (clr_s),
      .wr_en_i     (wr_fire_s && (wr_bank_q == 1'(b))),
      .wr_row_i    (wr_row_q),
      .wr_data_i   (in_data),
      .set_full_i  (wr_fire_s && wr_last_s && (wr_bank_q == 1'(b))),
      .set_empty_i (rel_s && (rd_bank_q == 1'(b))),
      .rows_o      (rows_s[b]),
      .flag_o      (flag_s[b])
    );
  end

`ifdef W_ZERO_PAD_EN
  logic [KERNEL_W-1:0] k_q, k_d;
  int                  pad_from_s;

  assign k_d        = (state_q == ST_DECIDE && nt_ok_s) ? kernel : k_q;
  assign pad_from_s = int'(k_q) * int'(k_q) - (int'(nt_q) - 1) * COLUMN_WIDTH;

  // Kernel size latched at DECIDE for the last-tile padding boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q <= '0;
    end else if (clr_s) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end
`endif

  // FSM next state, tile-count latch and configuration error.
  always_comb begin
    state_d   = state_q;
    nt_d      = nt_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = conv_en ? ST_DECIDE : ST_IDLE;
      end
      ST_DECIDE: begin
        if (nt_ok_s) begin
          state_d = ST_RUN;
          nt_d    = NT_W'(nt_calc_s);
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write pointer and read-side tile/bank sequencing.
  always_comb begin
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    tile_d    = tile_q;
    if (wr_fire_s && wr_last_s) begin
      wr_row_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_fire_s) begin
      wr_row_d = wr_row_q + ROW_AW'(1);
    end else begin
      wr_row_d = wr_row_q;
    end
    if (rel_s) begin
      tile_d    = '0;
      rd_bank_d = ~rd_bank_q;
    end else if (acc_s) begin
      tile_d = last_tile_s ? '0 : tile_q + TIDX_W'(1);
    end else begin
      tile_d = tile_q;
    end
  end

  // Gather column slice tile_d of every row; row 0 lands in the MSBs.
  always_comb begin
    logic [DATA_WIDTH-1:0] elem;
    tile_data_s = '0;
    elem        = '0;
    for (int r = 0; r < ROW_WIDTH; r++) begin
      for (int c = 0; c < COLUMN_WIDTH; c++) begin
        elem = rd_rows_s[r*ROW_BITS + int'(tile_d)*TROW_BITS + c*DATA_WIDTH +: DATA_WIDTH];
`ifdef W_ZERO_PAD_EN
        elem = (last_next_s && (c >= pad_from_s)) ? '0 : elem;
`endif
        tile_data_s[(ROW_WIDTH-1-r)*TROW_BITS + c*DATA_WIDTH +: DATA_WIDTH] = elem;
      end
    end
  end

  assign out_valid_d = run_s && !rel_s && (flag_s[rd_bank_q] == BANK_FULL);
  assign out_data_d  = out_valid_d ? tile_data_s : '0;
  assign we_done_d   = acc_s && last_tile_s;

  // Control state and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      nt_q        <= '0;
      cfg_err_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      tile_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      we_done_q   <= 1'b0;
    end else if (clr_s) begin
      state_q     <= ST_IDLE;
      nt_q        <= '0;
      cfg_err_q   <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      tile_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      we_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nt_q        <= nt_d;
      cfg_err_q   <= cfg_err_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      tile_q      <= tile_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      we_done_q   <= we_done_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_tile_idx = tile_q;
  assign we_done      = we_done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_w_tile_pingpong.sv
// Randomized bench for w_tile_pingpong against a row-queue reference model.
module tb_w_tile_pingpong;

  localparam int RW   = 10;
  localparam int CW   = 9;
  localparam int DW   = 16;
  localparam int MT   = 6;
  localparam int KW   = 3;
  localparam int TW   = (MT > 1) ? $clog2(MT) : 1;
  localparam int TRB  = CW * DW;
  localparam int RB   = MT * TRB;
  localparam int OB   = RW * TRB;

  logic          clk;
  logic          reset;
  logic          sudo_reset;
  logic          conv_en;
  logic [KW-1:0] kernel;
  logic          in_valid;
  logic          in_ready;
  logic [RB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;
  logic [TW-1:0] out_tile_idx;
  logic          we_done;
  logic          we_valid_del;
  logic          cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the buffer is a queue of accepted rows, at most two groups deep.
  logic [RB-1:0] rowq[$];
  int            m_phase;
  int            m_nt;
  int            m_k;
  int            m_tile;
  bit            m_valid;
  bit            m_we_done;
  bit            m_cfg_err;

  w_tile_pingpong dut (
    .clk          (clk),
    .reset        (reset),
    .sudo_reset   (sudo_reset),
    .conv_en      (conv_en),
    .kernel       (kernel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tile_idx (out_tile_idx),
    .we_done      (we_done),
    .we_valid_del (we_valid_del),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    rowq.delete();
    m_phase   = 0;
    m_nt      = 0;
    m_k       = 0;
    m_tile    = 0;
    m_valid   = 1'b0;
    m_we_done = 1'b0;
    m_cfg_err = 1'b0;
  endtask

  function automatic logic [TRB-1:0] exp_row(input int r);
    logic [RB-1:0]  row;
    logic [TRB-1:0] res;
    row = rowq[r];
    res = '0;
    for (int c = 0; c < CW; c++) begin
      res[c*DW +: DW] = row[m_tile*TRB + c*DW +: DW];
`ifdef W_ZERO_PAD_EN
      if (m_tile == m_nt - 1 && c >= m_k * m_k - (m_nt - 1) * CW) res[c*DW +: DW] = '0;
`endif
    end
    return res;
  endfunction

  task automatic compare_outputs();
    bit exp_rdy;
    exp_rdy = (m_phase == 2) && (rowq.size() < 2 * RW);
    check_val("in_ready", 160'(in_ready), 160'(exp_rdy));
    check_val("out_valid", 160'(out_valid), 160'(m_valid));
    check_val("we_done", 160'(we_done), 160'(m_we_done));
    check_val("cfg_err", 160'(cfg_err), 160'(m_cfg_err));
    if (m_valid) begin
      check_val("tile_idx", 160'(out_tile_idx), 160'(m_tile));
      for (int r = 0; r < RW; r++)
        check_val($sformatf("tile%0d_row%0d", m_tile, r),
                  160'(out_data[(RW-1-r)*TRB +: TRB]), 160'(exp_row(r)));
    end
  endtask

  // One clock: decide model events from pre-edge inputs, clock, update, compare.
  task automatic step();
    bit            clr;
    bit            run;
    bit            rdy;
    bit            rel;
    bit            acc;
    bit            valid_next;
    int            ntc;
    logic [RB-1:0] din;
    clr = sudo_reset || !conv_en;
    run = (m_phase == 2);
    rdy = run && (rowq.size() < 2 * RW);
    rel = run && we_valid_del && (rowq.size() >= RW);
    acc = m_valid && out_ready && !rel;
    ntc = (int'(kernel) * int'(kernel) + CW - 1) / CW;
    din = in_data;
    valid_next = run && !rel && (rowq.size() >= RW);
    @(posedge clk);
    #1;
    if (clr) begin
      model_clear();
    end else begin
      m_we_done = acc && (m_tile == m_nt - 1);
      if (acc) m_tile = (m_tile == m_nt - 1) ? 0 : m_tile + 1;
      if (rel) begin
        repeat (RW) void'(rowq.pop_front());
        m_tile = 0;
      end
      if (in_valid && rdy) rowq.push_back(din);
      m_valid   = valid_next;
      m_cfg_err = (m_phase == 1) && !(ntc >= 1 && ntc <= MT);
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1 && ntc >= 1 && ntc <= MT) begin
        m_phase = 2;
        m_nt    = ntc;
        m_k     = int'(kernel);
      end
    end
    compare_outputs();
  endtask

  task automatic rand_row();
    for (int b = 0; b < RB; b += 32) in_data[b +: 32] = $urandom;
  endtask

  task automatic traffic(input int cycles, input int p_in, input int p_out, input int p_rel);
    for (int i = 0; i < cycles; i++) begin
      in_valid     = ($urandom_range(99) < p_in);
      out_ready    = ($urandom_range(99) < p_out);
      we_valid_del = ($urandom_range(99) < p_rel);
      rand_row();
      if (m_phase == 2 && $urandom_range(9) == 0) kernel = KW'($urandom);
      step();
    end
  endtask

  task automatic start_kernel(input int k);
    conv_en = 1'b0;
    in_valid = 1'b0;
    we_valid_del = 1'b0;
    step();
    kernel  = KW'(k);
    conv_en = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [OB-1:0] held;
    reset        = 1'b0;
    sudo_reset   = 1'b0;
    conv_en      = 1'b0;
    kernel       = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    we_valid_del = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", 160'(in_ready), 160'(0));
    check_val("rst_out_valid", 160'(out_valid), 160'(0));
    check_val("rst_out_data", 160'(out_data[159:0]), 160'(0));
    check_val("rst_we_done", 160'(we_done), 160'(0));
    check_val("rst_cfg_err", 160'(cfg_err), 160'(0));
    reset = 1'b1;
    step();

    // K=3: single tile replayed.
    start_kernel(3);
    traffic(300, 70, 80, 4);

    // Fill both banks, then stall five cycles and check the tile holds.
    in_valid = 1'b1;
    out_ready = 1'b0;
    we_valid_del = 1'b0;
    for (int i = 0; i < 3 * RW && in_ready; i++) begin
      rand_row();
      step();
    end
    in_valid = 1'b1;
    rand_row();
    step();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall_valid", 160'(out_valid), 160'(1));
      check_val("stall_data", 160'(out_data[OB-1 -: 160]), 160'(held[OB-1 -: 160]));
    end
    out_ready = 1'b1;
    we_valid_del = 1'b1;
    step();
    we_valid_del = 1'b0;
    traffic(20, 50, 90, 0);

    // K=6: four tiles with wrap.
    start_kernel(6);
    traffic(400, 70, 75, 3);

    // Soft reset in the middle of a load.
    traffic(5, 100, 50, 0);
    sudo_reset = 1'b1;
    step();
    sudo_reset = 1'b0;
    traffic(200, 70, 80, 4);

    // Unsupported kernel sits in DECIDE with cfg_err.
    start_kernel(0);
    for (int i = 0; i < 4; i++) step();
    conv_en = 1'b0;
    step();

    // K=5 exercises the partial last tile, K=7 the full tile range.
    start_kernel(5);
    traffic(300, 70, 80, 4);
    start_kernel(7);
    traffic(300, 70, 80, 3);

    // Asynchronous reset away from a clock edge.
    #3;
    reset = 1'b0;
    #1;
    check_val("arst_in_ready", 160'(in_ready), 160'(0));
    check_val("arst_out_valid", 160'(out_valid), 160'(0));
    check_val("arst_tile_idx", 160'(out_tile_idx), 160'(0));
    check_val("arst_we_done", 160'(we_done), 160'(0));
    model_clear();
    #2;
    reset = 1'b1;
    traffic(150, 70, 80, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
